// File: rtl/jpeg_bit_packer.sv
// JPEG entropy bitstream packer: MSB-first code word concatenation, 1-padding on flush.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 after every emitted 0xFF byte.
module jpeg_bit_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_bits,
    input  logic [5:0]  in_len,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        flush_done,
    output logic [6:0]  bit_count
);

    localparam logic [63:0] TOP_BYTE = 64'hFF00_0000_0000_0000;

    logic [63:0] acc_q, acc_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [7:0]  obyte_q, obyte_d;
    logic        ovalid_q, ovalid_d;
    logic        flushing_q, flushing_d;

    logic        stuffPending;
    logic        slotFree;
    logic        doExtract;
    logic        padNow;
    logic        accept;
    logic        flushDone;
    logic [6:0]  lenEff;
    logic [6:0]  appendCnt;
    logic [6:0]  shiftAmt;
    logic [31:0] wordMasked;

    assign slotFree  = !ovalid_q || out_ready;
    assign doExtract = slotFree && !stuffPending && (cnt_q >= 7'd8);
    assign padNow    = flushing_q && (cnt_q != 7'd0) && (cnt_q < 7'd8) && !doExtract;
    assign in_ready  = !flushing_q && (cnt_q <= 7'd32);
    assign accept    = in_valid && in_ready;
    assign flushDone = flushing_q && (cnt_q == 7'd0) && !stuffPending && slotFree;

    // Over-long lengths saturate at 32; a shift of 32 leaves 0, so the -1 gives all ones.
    assign lenEff     = (in_len > 6'd32) ? 7'd32 : {1'b0, in_len};
    assign wordMasked = in_bits & ((32'd1 << lenEff) - 32'd1);
    assign appendCnt  = doExtract ? (cnt_q - 7'd8) : cnt_q;
    assign shiftAmt   = 7'd64 - appendCnt - lenEff;

`ifdef JPEG_BYTE_STUFF_EN
    logic stuffPending_q, stuffPending_d;

    always_comb begin
        stuffPending_d = stuffPending_q;
        if (slotFree) begin
            if (stuffPending_q) begin
                stuffPending_d = 1'b0;
            end else if (cnt_q >= 7'd8) begin
                stuffPending_d = (acc_q[63:56] == 8'hFF);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stuffPending_q <= 1'b0;
        end else begin
            stuffPending_q <= stuffPending_d;
        end
    end

    assign stuffPending = stuffPending_q;
`else
    assign stuffPending = 1'b0;
`endif

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        obyte_d    = obyte_q;
        ovalid_d   = ovalid_q;
        flushing_d = flushing_q;

        if (slotFree) begin
            if (stuffPending) begin
                obyte_d  = 8'h00;
                ovalid_d = 1'b1;
            end else if (cnt_q >= 7'd8) begin
                obyte_d  = acc_q[63:56];
                ovalid_d = 1'b1;
                acc_d    = acc_q << 8;
                cnt_d    = cnt_q - 7'd8;
            end else begin
                ovalid_d = 1'b0;
            end
        end

        // Padding only happens while flushing, when in_ready is low, so it never meets an append.
        if (padNow) begin
            acc_d = acc_d | ((TOP_BYTE >> cnt_q) & TOP_BYTE);
            cnt_d = 7'd8;
        end

        if (accept) begin
            acc_d = acc_d | ({32'd0, wordMasked} << shiftAmt);
            cnt_d = appendCnt + lenEff;
            if (in_flush) begin
                flushing_d = 1'b1;
            end
        end

        if (flushDone) begin
            flushing_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= 64'd0;
            cnt_q      <= 7'd0;
            obyte_q    <= 8'h00;
            ovalid_q   <= 1'b0;
            flushing_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            obyte_q    <= obyte_d;
            ovalid_q   <= ovalid_d;
            flushing_q <= flushing_d;
        end
    end

    assign out_valid  = ovalid_q;
    assign out_byte   = obyte_q;
    assign flush_done = flushDone;
    assign bit_count  = cnt_q;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed self-checking bench for jpeg_bit_packer; expectations follow JPEG_BYTE_STUFF_EN when defined.
module tb_jpeg_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_bits;
    logic [5:0]  in_len;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        flush_done;
    logic [6:0]  bit_count;

    int checks = 0;
    int failures = 0;
    int flushPulses = 0;
    int overlapCount = 0;
    logic [7:0] gotBytes[$];
    logic [7:0] expBytes[$];

    jpeg_bit_packer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .flush_done (flush_done),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    // Inputs change just after the rising edge, so the falling edge sees the values that the next rising edge will act on.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) gotBytes.push_back(out_byte);
            if (flush_done) flushPulses++;
            if (flush_done && in_ready) overlapCount++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Holds the beat until it is accepted, with a bounded wait.
    task automatic applyStimulus(input logic [31:0] bits, input logic [5:0] len, input logic flush);
        int budget;
        in_valid = 1'b1;
        in_bits  = bits;
        in_len   = len;
        in_flush = flush;
        budget   = 200;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_bits  = 32'd0;
        in_len   = 6'd0;
    endtask

    task automatic checkBytes(input string tag);
        checkOutput({tag, "_count"}, 64'(gotBytes.size()), 64'(expBytes.size()));
        for (int i = 0; i < expBytes.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < gotBytes.size()) ? {56'd0, gotBytes[i]} : {64{1'bx}},
                        {56'd0, expBytes[i]});
        end
        gotBytes.delete();
        expBytes.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bits   = 32'd0;
        in_len    = 6'd0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_byte", 64'(out_byte), 64'h00);
        checkOutput("rst_flush_done", 64'(flush_done), 64'd0);
        checkOutput("rst_bit_count", 64'(bit_count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] two-bit code words packed into 0xAA bytes");
        for (int i = 0; i < 4; i++) applyStimulus(32'h2, 6'd2, 1'b0);
        checkOutput("aa_cnt_before", 64'(bit_count), 64'd8);
        checkOutput("aa_valid_before", 64'(out_valid), 64'd0);
        tick();
        checkOutput("aa_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("aa_latency_byte", 64'(out_byte), 64'hAA);
        checkOutput("aa_cnt_after", 64'(bit_count), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h2, 6'd2, 1'b0);
        drain(4);
        checkOutput("aa_cnt_final", 64'(bit_count), 64'd0);
        expBytes = '{8'hAA, 8'hAA};
        checkBytes("aa");

        $display("[TB] 16 ones with flush");
        flushPulses = 0;
        applyStimulus(32'hFFFF, 6'd16, 1'b1);
        checkOutput("ff_in_ready_flushing", 64'(in_ready), 64'd0);
        drain(8);
`ifdef JPEG_BYTE_STUFF_EN
        expBytes = '{8'hFF, 8'h00, 8'hFF, 8'h00};
`else
        expBytes = '{8'hFF, 8'hFF};
`endif
        checkBytes("ff");
        checkOutput("ff_flush_pulses", 64'(flushPulses), 64'd1);
        checkOutput("ff_in_ready_after", 64'(in_ready), 64'd1);

        $display("[TB] three bits with flush padding");
        flushPulses = 0;
        applyStimulus(32'h5, 6'd3, 1'b1);
        drain(6);
        expBytes = '{8'hBF};
        checkBytes("pad");
        checkOutput("pad_flush_pulses", 64'(flushPulses), 64'd1);
        checkOutput("pad_cnt", 64'(bit_count), 64'd0);

        $display("[TB] over-long length saturates at 32 bits");
        flushPulses = 0;
        applyStimulus(32'h8000_0001, 6'd40, 1'b1);
        drain(8);
        expBytes = '{8'h80, 8'h00, 8'h00, 8'h01};
        checkBytes("len40");
        checkOutput("len40_flush_pulses", 64'(flushPulses), 64'd1);

        $display("[TB] backpressure with four 16-bit words");
        out_ready = 1'b0;
        applyStimulus(32'h1234, 6'd16, 1'b0);
        applyStimulus(32'h5678, 6'd16, 1'b0);
        applyStimulus(32'h9ABC, 6'd16, 1'b0);
        checkOutput("bp_cnt", 64'(bit_count), 64'd40);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_out_byte", 64'(out_byte), 64'h12);
        in_valid = 1'b1;
        in_bits  = 32'hDEF0;
        in_len   = 6'd16;
        drain(3);
        checkOutput("bp_hold_byte", 64'(out_byte), 64'h12);
        checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        applyStimulus(32'hDEF0, 6'd16, 1'b0);
        drain(10);
        expBytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        checkBytes("bp");

        $display("[TB] reset with buffered bits");
        out_ready = 1'b0;
        applyStimulus(32'hABCDE, 6'd20, 1'b0);
        applyStimulus(32'h5A, 6'd8, 1'b0);
        checkOutput("mr_pre_cnt", 64'(bit_count), 64'd20);
        checkOutput("mr_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mr_bit_count", 64'(bit_count), 64'd0);
        checkOutput("mr_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drain(6);
        checkBytes("mr");

        $display("[TB] empty flush");
        flushPulses = 0;
        applyStimulus(32'hFFFF_FFFF, 6'd0, 1'b1);
        checkOutput("ef_flush_done", 64'(flush_done), 64'd1);
        checkOutput("ef_in_ready_during", 64'(in_ready), 64'd0);
        tick();
        checkOutput("ef_flush_done_after", 64'(flush_done), 64'd0);
        checkOutput("ef_in_ready_after", 64'(in_ready), 64'd1);
        drain(3);
        checkBytes("ef");
        checkOutput("ef_flush_pulses", 64'(flushPulses), 64'd1);

        checkOutput("done_ready_overlap", 64'(overlapCount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
